// File: rtl/spike_mc_pkg.sv
// Shared definitions for the multi-channel spike detector: register map,
// identification constant, event record layout and the deviation helper.
package spike_mc_pkg;

   localparam logic [13:0] ADDR_ID         = 14'h0000;
   localparam logic [13:0] ADDR_CTRL       = 14'h0001;
   localparam logic [13:0] ADDR_STATUS     = 14'h0002;
   localparam logic [13:0] ADDR_FIFO_LEVEL = 14'h0003;
   localparam logic [13:0] ADDR_EVT_CHAN   = 14'h0004;
   localparam logic [13:0] ADDR_EVT_TS_LO  = 14'h0005;
   localparam logic [13:0] ADDR_EVT_TS_HI  = 14'h0006;
   localparam logic [13:0] ADDR_REFRACT    = 14'h0007;
   localparam logic [13:0] ADDR_THRESH     = 14'h0010;
   localparam logic [13:0] ADDR_MEAN       = 14'h0020;

   localparam logic [15:0] ID_VALUE        = 16'h5D02;

   typedef struct packed {
      logic [3:0]  chan;
      logic [31:0] ts;
   } evt_t;

   // Magnitude of a - b; operands arrive sign-extended to 32 bits so the
   // difference of two sample-range values can never overflow.
   function automatic logic [31:0] abs_diff(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
      logic signed [31:0] d;
      d = a - b;
      if (d < 32'sd0) begin
         abs_diff = 32'(-d);
      end else begin
         abs_diff = 32'(d);
      end
   endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO with show-ahead head. A push while full is only
// accepted when a pop happens in the same cycle.
module spike_evt_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 36
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       din_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push_s, do_pop_s;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Next pointers and fill level from the accepted push/pop pair.
   always_comb begin
      do_pop_s  = pop_i && !empty_o;
      do_push_s = push_i && (!full_o || do_pop_s);
      wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d   = level_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
   end

   // Pointer and level state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/spike_detection_mc_avalon.sv
// Multi-channel spike detector: per-channel running mean, threshold and
// refractory suppression, timestamped events in a shared FIFO read over
// Avalon-MM, level IRQ on new events or overflow.
module spike_detection_mc_avalon
   import spike_mc_pkg::*;
#(
   parameter int NB_CHANNELS = 4,
   parameter int SAMPLE_W    = 16,
   parameter int AVG_SHIFT   = 4,
   parameter int FIFO_DEPTH  = 32
) (
   input  logic                            avl_clk_i,
   input  logic                            avl_reset_i,
   input  logic [13:0]                     avl_address_i,
   input  logic [3:0]                      avl_byteenable_i,
   input  logic                            avl_write_i,
   input  logic [15:0]                     avl_writedata_i,
   input  logic                            avl_read_i,
   output logic                            avl_readdatavalid_o,
   output logic [15:0]                     avl_readdata_o,
   output logic                            avl_waitrequest_o,
   output logic                            avl_irq_o,
   input  logic [NB_CHANNELS*SAMPLE_W-1:0] sample_i,
   input  logic [NB_CHANNELS-1:0]          sample_valid_i
);
   localparam int ACC_W = SAMPLE_W + AVG_SHIFT + 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  ctrl_q, ctrl_d;
   logic        ovf_q, ovf_d, irq_pend_q, irq_pend_d, irq_q, irq_d;
   logic [15:0] refract_q, refract_d;
   logic [31:0] ts_q, ts_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;

   logic [15:0]             thresh_q [NB_CHANNELS];
   logic [15:0]             thresh_d [NB_CHANNELS];
   logic signed [ACC_W-1:0] acc_q [NB_CHANNELS];
   logic signed [ACC_W-1:0] acc_d [NB_CHANNELS];
   logic [15:0]             refr_q [NB_CHANNELS];
   logic [15:0]             refr_d [NB_CHANNELS];
   logic [31:0]             pend_ts_q [NB_CHANNELS];
   logic [31:0]             pend_ts_d [NB_CHANNELS];
   logic [NB_CHANNELS-1:0]  pend_q, pend_d;

   logic signed [SAMPLE_W-1:0] x_s [NB_CHANNELS];
   logic signed [ACC_W-1:0]    mean_s [NB_CHANNELS];
   logic [NB_CHANNELS-1:0]     hit_s;

   logic             wr_s, rd_s, commit_s, drop_s, ovf_set_s;
   logic             push_s, pop_s, full_s, empty_s;
   logic [3:0]       commit_idx_s;
   logic [31:0]      commit_ts_s;
   logic [LVL_W-1:0] level_s;
   evt_t             push_evt_s, head_s;
   logic             unused_be_s;

   assign unused_be_s         = ^avl_byteenable_i;
   assign avl_waitrequest_o   = 1'b0;
   assign avl_readdata_o      = rdata_q;
   assign avl_readdatavalid_o = rvalid_q;
   assign avl_irq_o           = irq_q;
   assign wr_s                = avl_write_i;
   assign rd_s                = avl_read_i & ~avl_write_i;

   // Per-channel mean (value before this sample's update) and spike decision.
   for (genvar g = 0; g < NB_CHANNELS; g++) begin : g_chan
      assign x_s[g]    = sample_i[g*SAMPLE_W +: SAMPLE_W];
      assign mean_s[g] = acc_q[g] >>> AVG_SHIFT;
      assign hit_s[g]  = (abs_diff(32'(x_s[g]), 32'(mean_s[g])) > 32'(thresh_q[g]))
                         && (refr_q[g] == 16'd0);
   end

   // Control register writes and the timestamp counter.
   always_comb begin
      ctrl_d    = ctrl_q;
      refract_d = refract_q;
      thresh_d  = thresh_q;
      ts_d      = ctrl_q[0] ? ts_q + 32'd1 : ts_q;
      if (wr_s) begin
         case (avl_address_i)
            ADDR_CTRL: begin
               ctrl_d = avl_writedata_i[1:0];
               if (avl_writedata_i[0] && !ctrl_q[0]) begin
                  ts_d = 32'd0;
               end else begin
                  ts_d = ctrl_q[0] ? ts_q + 32'd1 : ts_q;
               end
            end
            ADDR_REFRACT: refract_d = avl_writedata_i;
            default:      ctrl_d = ctrl_q;
         endcase
         for (int c = 0; c < NB_CHANNELS; c++) begin
            if (avl_address_i == ADDR_THRESH + 14'(c)) begin
               thresh_d[c] = avl_writedata_i;
            end
         end
      end else begin
         ctrl_d = ctrl_q;
      end
   end

   // Lowest-index pending channel owns the FIFO write port this cycle.
   always_comb begin
      commit_s     = 1'b0;
      commit_idx_s = 4'd0;
      commit_ts_s  = 32'd0;
      for (int c = NB_CHANNELS - 1; c >= 0; c--) begin
         if (pend_q[c]) begin
            commit_s     = 1'b1;
            commit_idx_s = 4'(c);
            commit_ts_s  = pend_ts_q[c];
         end
      end
   end

   assign push_evt_s = {commit_idx_s, commit_ts_s};

   // Running mean, refractory count and pending-event capture per channel.
   always_comb begin
      acc_d     = acc_q;
      refr_d    = refr_q;
      pend_ts_d = pend_ts_q;
      pend_d    = pend_q;
      drop_s    = 1'b0;
      for (int c = 0; c < NB_CHANNELS; c++) begin
         if (commit_s && (commit_idx_s == 4'(c))) begin
            pend_d[c] = 1'b0;
         end
         if (ctrl_q[0] && sample_valid_i[c]) begin
            acc_d[c] = acc_q[c] + ACC_W'(x_s[c]) - mean_s[c];
            if (hit_s[c]) begin
               refr_d[c] = refract_q;
               if (pend_d[c]) begin
                  drop_s = 1'b1;
               end else begin
                  pend_d[c]    = 1'b1;
                  pend_ts_d[c] = ts_q;
               end
            end else if (refr_q[c] != 16'd0) begin
               refr_d[c] = refr_q[c] - 16'd1;
            end else begin
               refr_d[c] = refr_q[c];
            end
         end
      end
   end

   // FIFO handshake, sticky overflow and interrupt pending; set beats clear.
   always_comb begin
      pop_s      = rd_s && (avl_address_i == ADDR_EVT_TS_HI) && !empty_s;
      push_s     = commit_s && (!full_s || pop_s);
      ovf_set_s  = drop_s || (commit_s && full_s && !pop_s);
      ovf_d      = ovf_q;
      irq_pend_d = irq_pend_q;
      if (wr_s && (avl_address_i == ADDR_STATUS)) begin
         if (avl_writedata_i[1]) ovf_d = 1'b0;
         else                    ovf_d = ovf_q;
         if (avl_writedata_i[2]) irq_pend_d = 1'b0;
         else                    irq_pend_d = irq_pend_q;
      end
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end
      if ((push_s && empty_s) || (ovf_set_s && !ovf_q)) begin
         irq_pend_d = 1'b1;
      end
      irq_d = irq_pend_q & ctrl_q[1];
   end

   // Registered read-back; zero whenever no read is being answered.
   always_comb begin
      rvalid_d = rd_s;
      rdata_d  = 16'd0;
      if (rd_s) begin
         case (avl_address_i)
            ADDR_ID:         rdata_d = ID_VALUE;
            ADDR_CTRL:       rdata_d = {14'd0, ctrl_q};
            ADDR_STATUS:     rdata_d = {13'd0, irq_pend_q, ovf_q, !empty_s};
            ADDR_FIFO_LEVEL: rdata_d = 16'(level_s);
            ADDR_EVT_CHAN:   rdata_d = empty_s ? 16'd0 : {12'd0, head_s.chan};
            ADDR_EVT_TS_LO:  rdata_d = empty_s ? 16'd0 : head_s.ts[15:0];
            ADDR_EVT_TS_HI:  rdata_d = empty_s ? 16'd0 : head_s.ts[31:16];
            ADDR_REFRACT:    rdata_d = refract_q;
            default:         rdata_d = 16'd0;
         endcase
         for (int c = 0; c < NB_CHANNELS; c++) begin
            if (avl_address_i == ADDR_THRESH + 14'(c)) rdata_d = thresh_q[c];
            if (avl_address_i == ADDR_MEAN + 14'(c))   rdata_d = 16'(mean_s[c]);
         end
      end else begin
         rdata_d = 16'd0;
      end
   end

   // All architectural state, cleared by the synchronous reset.
   always_ff @(posedge avl_clk_i) begin
      if (avl_reset_i) begin
         ctrl_q     <= 2'd0;
         ovf_q      <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_q      <= 1'b0;
         refract_q  <= 16'd0;
         ts_q       <= 32'd0;
         rdata_q    <= 16'd0;
         rvalid_q   <= 1'b0;
         pend_q     <= '0;
         for (int c = 0; c < NB_CHANNELS; c++) begin
            thresh_q[c]  <= 16'h7FFF;
            acc_q[c]     <= '0;
            refr_q[c]    <= 16'd0;
            pend_ts_q[c] <= 32'd0;
         end
      end else begin
         ctrl_q     <= ctrl_d;
         ovf_q      <= ovf_d;
         irq_pend_q <= irq_pend_d;
         irq_q      <= irq_d;
         refract_q  <= refract_d;
         ts_q       <= ts_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         pend_q     <= pend_d;
         thresh_q   <= thresh_d;
         acc_q      <= acc_d;
         refr_q     <= refr_d;
         pend_ts_q  <= pend_ts_d;
      end
   end

   spike_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(evt_t))
   ) u_fifo (
      .clk_i   (avl_clk_i),
      .rst_i   (avl_reset_i),
      .push_i  (push_s),
      .din_i   (push_evt_s),
      .pop_i   (pop_s),
      .head_o  (head_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .level_o (level_s)
   );

endmodule

// File: tb/tb_spike_detection_mc_avalon.sv
// Scenario bench for the multi-channel spike detector. Expected events are
// queued as spiking samples are driven and compared as the FIFO is drained.
module tb_spike_detection_mc_avalon;
   localparam int NB = 4;
   localparam int SW = 16;

   typedef struct {
      logic [3:0]  chan;
      logic [31:0] ts;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst, wr, rd, rvalid, waitreq, irq;
   logic [13:0]       addr;
   logic [3:0]        be;
   logic [15:0]       wdata, rdata;
   logic [NB*SW-1:0]  sample;
   logic [NB-1:0]     svalid;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ts_base = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spike_detection_mc_avalon dut (
      .avl_clk_i           (clk),
      .avl_reset_i         (rst),
      .avl_address_i       (addr),
      .avl_byteenable_i    (be),
      .avl_write_i         (wr),
      .avl_writedata_i     (wdata),
      .avl_read_i          (rd),
      .avl_readdatavalid_o (rvalid),
      .avl_readdata_o      (rdata),
      .avl_waitrequest_o   (waitreq),
      .avl_irq_o           (irq),
      .sample_i            (sample),
      .sample_valid_i      (svalid)
   );

   // waitrequest must stay low on every cycle
   always @(negedge clk) begin
      total++;
      if (waitreq !== 1'b0) begin
         bad++;
         $display("FAIL waitrequest got=%b want=0", waitreq);
      end
   end

   task automatic do_reset();
      rst = 1'b1; wr = 1'b0; rd = 1'b0; svalid = '0; sample = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic wr_reg(input logic [13:0] a, input logic [15:0] d);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [13:0] a, output logic [15:0] d);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = (rvalid === 1'b1) ? rdata : 16'hxxxx;
   endtask

   task automatic drive(input logic [NB-1:0] mask, input logic [15:0] v);
      for (int c = 0; c < NB; c++) sample[c*SW +: SW] = v;
      svalid = mask;
      @(negedge clk);
      svalid = '0;
   endtask

   task automatic expect_evt(input logic [3:0] ch);
      exp_t e;
      e.chan = ch;
      e.ts   = 32'(cyc - ts_base);
      sb.push_back(e);
   endtask

   task automatic drain_events(input string tag);
      logic [15:0] c, lo, hi;
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_reg(14'h0004, c);
         rd_reg(14'h0005, lo);
         rd_reg(14'h0006, hi);
         total++;
         if (c !== {12'd0, e.chan}) begin
            bad++; $display("FAIL %s evt_chan got=%h want=%h", tag, c, e.chan);
         end
         total++;
         if ({hi, lo} !== e.ts) begin
            bad++; $display("FAIL %s evt_ts got=%h want=%h", tag, {hi, lo}, e.ts);
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_reset();
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
      total++;
      if (rvalid !== 1'b0 || rdata !== 16'd0) begin
         bad++; $display("FAIL rst_idle got=%b/%h want=0/0", rvalid, rdata);
      end
      rd_reg(14'h0000, d); total++;
      if (d !== 16'h5D02) begin bad++; $display("FAIL rst_id got=%h want=5d02", d); end
      rd_reg(14'h0002, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL rst_status got=%h want=0", d); end
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL rst_level got=%h want=0", d); end
      rd_reg(14'h0012, d); total++;
      if (d !== 16'h7FFF) begin bad++; $display("FAIL rst_thresh got=%h want=7fff", d); end
      rd_reg(14'h0030, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL unmapped got=%h want=0", d); end
      // read and write together: write lands, no read response
      addr = 14'h0007; wdata = 16'h0005; wr = 1'b1; rd = 1'b1;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      total++;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL rdwr_valid got=%b want=0", rvalid); end
      rd_reg(14'h0007, d); total++;
      if (d !== 16'h0005) begin bad++; $display("FAIL rdwr_refract got=%h want=0005", d); end
   endtask

   task automatic test_single_spike();
      logic [15:0] d;
      do_reset();
      wr_reg(14'h0010, 16'd100);
      wr_reg(14'h0001, 16'h0003);
      ts_base = cyc;
      repeat (20) drive(4'b0001, 16'd0);
      expect_evt(4'd0);
      drive(4'b0001, 16'd500);
      for (int i = 0; i < 6 && irq !== 1'b1; i++) @(negedge clk);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL single_irq_rise got=%b want=1", irq); end
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd1) begin bad++; $display("FAIL single_level got=%0d want=1", d); end
      rd_reg(14'h0002, d); total++;
      if (d !== 16'h0005) begin bad++; $display("FAIL single_status got=%h want=0005", d); end
      drain_events("single");
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL single_level_after got=%0d want=0", d); end
      rd_reg(14'h0006, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL single_empty_pop got=%h want=0", d); end
      wr_reg(14'h0002, 16'h0004);
      @(negedge clk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL single_irq_clear got=%b want=0", irq); end
   endtask

   task automatic test_refractory();
      logic [15:0] d;
      do_reset();
      wr_reg(14'h0011, 16'd50);
      wr_reg(14'h0007, 16'd3);
      wr_reg(14'h0001, 16'h0003);
      ts_base = cyc;
      for (int i = 1; i <= 5; i++) begin
         if (i == 1 || i == 5) expect_evt(4'd1);
         drive(4'b0010, 16'd200);
      end
      repeat (4) @(negedge clk);
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd2) begin bad++; $display("FAIL refract_level got=%0d want=2", d); end
      drain_events("refract");
   endtask

   task automatic test_all_channels();
      logic [15:0] d;
      do_reset();
      for (int c = 0; c < NB; c++) wr_reg(14'h0010 + 14'(c), 16'd10);
      wr_reg(14'h0001, 16'h0003);
      ts_base = cyc;
      for (int c = 0; c < NB; c++) expect_evt(4'(c));
      drive(4'b1111, 16'd1000);
      repeat (6) @(negedge clk);
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd4) begin bad++; $display("FAIL allch_level got=%0d want=4", d); end
      drain_events("allch");
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      do_reset();
      wr_reg(14'h0010, 16'd10);
      wr_reg(14'h0001, 16'h0003);
      ts_base = cyc;
      for (int i = 0; i < 33; i++) begin
         if (i < 32) expect_evt(4'd0);
         drive(4'b0001, (i % 2 == 0) ? 16'd1000 : 16'hFC18);
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd32) begin bad++; $display("FAIL ovf_level got=%0d want=32", d); end
      rd_reg(14'h0002, d); total++;
      if (d !== 16'h0007) begin bad++; $display("FAIL ovf_status got=%h want=0007", d); end
      wr_reg(14'h0002, 16'h0002);
      rd_reg(14'h0002, d); total++;
      if (d !== 16'h0005) begin bad++; $display("FAIL ovf_w1c got=%h want=0005", d); end
      drain_events("ovf");
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL ovf_no_33rd got=%0d want=0", d); end
   endtask

   task automatic test_mean();
      logic [15:0] d;
      int acc;
      int m;
      do_reset();
      wr_reg(14'h0001, 16'h0001);
      acc = 0;
      for (int i = 0; i < 256; i++) begin
         acc = acc + 1600 - (acc >>> 4);
         drive(4'b0100, 16'd1600);
         if (i == 63) begin
            rd_reg(14'h0022, d); total++;
            if (d !== 16'(acc >>> 4)) begin
               bad++; $display("FAIL mean_64 got=%0d want=%0d", d, acc >>> 4);
            end
         end
      end
      m = acc >>> 4;
      rd_reg(14'h0022, d); total++;
      if (d !== 16'(m) || int'(d) < 1599 || int'(d) > 1601) begin
         bad++; $display("FAIL mean_settled got=%0d want=%0d", d, m);
      end
      wr_reg(14'h0001, 16'h0000);
      repeat (10) drive(4'b0100, 16'd0);
      rd_reg(14'h0022, d); total++;
      if (d !== 16'(m)) begin bad++; $display("FAIL mean_frozen got=%0d want=%0d", d, m); end
      rd_reg(14'h0003, d); total++;
      if (d !== 16'd0) begin bad++; $display("FAIL mean_no_events got=%0d want=0", d); end
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
      be = 4'hF; sample = '0; svalid = '0;
      @(negedge clk);
      test_reset();
      test_single_spike();
      test_refractory();
      test_all_channels();
      test_overflow();
      test_mean();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
